// File: rtl/fetch_unit.sv
// Fetch stage: drives program_counter, reads synchronous imem, buffers up to 2 instructions for decode.
// Issue-to-valid latency 2 cycles; issue stalls while buffered + returning entries would exceed 2.
module fetch_unit #(
  parameter int                 PC_W       = 9,
  parameter int                 INSTR_W    = 9,
  parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(9'h1FF)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_next,
  output logic               pc_write,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  state_t          state_q, state_d;
  entry_t          head_q, head_d, tail_q, tail_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] tag_q, tag_d;
  logic            done_q, done_d;

  logic       pop, push, redirect, halt_ret, issue;
  logic [2:0] occ;
  entry_t     resp;

  assign resp     = {imem_rdata, tag_q};
  assign pop      = (cnt_q != 2'd0) && instr_ready;
  assign redirect = branch_taken && ((state_q == FETCH) || (state_q == DRAIN));
  // A response returning in a redirect cycle belongs to the old path and is dropped.
  assign push     = inflight_q && !redirect;
  assign halt_ret = push && (imem_rdata == HALT_INSTR);
  assign occ      = {1'b0, cnt_q} - {2'b0, pop} + {2'b0, inflight_q};
  assign issue    = (state_q == FETCH) && !redirect && !halt_ret && (occ < 3'd2);

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    cnt_d      = cnt_q;
    inflight_d = issue;
    tag_d      = tag_q;
    done_d     = done_q;
    pc_next    = pc;
    pc_write   = 1'b0;
    imem_en    = 1'b0;

    if (issue) begin
      imem_en  = 1'b1;
      pc_write = 1'b1;
      pc_next  = pc + PC_W'(1);
      tag_d    = pc;
    end
    if (redirect) begin
      pc_write = 1'b1;
      pc_next  = branch_target;
    end

    if (pop) begin
      head_d = tail_q;
      cnt_d  = cnt_q - 2'd1;
    end
    if (push) begin
      // Slot written is the first one left free after this cycle's pop.
      if (cnt_q == {1'b0, pop}) head_d = resp;
      else                      tail_d = resp;
      cnt_d = cnt_d + 2'd1;
    end
    if (redirect) cnt_d = 2'd0;

    case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: if (halt_ret) state_d = DRAIN;
      DRAIN: begin
        if (redirect) begin
          state_d = FETCH;
        end else if (pop && (head_q.instr == HALT_INSTR)) begin
          state_d = HALT;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      done_q     <= done_d;
    end
  end

  assign imem_addr   = pc;
  assign instr       = head_q.instr;
  assign instr_pc    = head_q.pc;
  assign instr_valid = (cnt_q != 2'd0);
  assign done        = done_q;

endmodule
